// File: rtl/cordic_z_serial.sv
// ============================================================================
//  Module      : cordic_z_serial
//  Description : Bit-serial residual-angle (z) datapath of a CORDIC engine.
//                One full-adder slice per clock, LSB first, one word per
//                iteration; exports per-iteration direction and strobes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cordic_z_serial #(
    parameter int WIDTH  = 16,
    parameter int ITERS  = 16,
    parameter int ITER_W = 5,
    parameter int BIT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [WIDTH-1:0]  z0,
    input  logic              dir_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  z_out,
    output logic              dir_out,
    output logic              iter_start,
    output logic [ITER_W-1:0] iter_idx
);

    localparam int C_ITER_SPAN = 2 ** ITER_W;
    localparam int C_BIT_SPAN  = 2 ** BIT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // atan(2^-i) scaled so that 2^31 = pi, used as a high-precision reference
    function automatic logic [31:0] atan_ref32(input int i);
        case (i)
            0:  return 32'h2000_0000;
            1:  return 32'h12E4_051E;
            2:  return 32'h09FB_385B;
            3:  return 32'h0511_11D4;
            4:  return 32'h028B_0D43;
            5:  return 32'h0145_D7E1;
            6:  return 32'h00A2_F61E;
            7:  return 32'h0051_7C55;
            8:  return 32'h0028_BE53;
            9:  return 32'h0014_5F2F;
            10: return 32'h000A_2F98;
            11: return 32'h0005_17CC;
            12: return 32'h0002_8BE6;
            13: return 32'h0001_45F3;
            14: return 32'h0000_A2FA;
            15: return 32'h0000_517D;
            16: return 32'h0000_28BE;
            17: return 32'h0000_145F;
            18: return 32'h0000_0A30;
            19: return 32'h0000_0518;
            20: return 32'h0000_028C;
            21: return 32'h0000_0146;
            22: return 32'h0000_00A3;
            23: return 32'h0000_0051;
            24: return 32'h0000_0029;
            25: return 32'h0000_0014;
            26: return 32'h0000_000A;
            27: return 32'h0000_0005;
            28: return 32'h0000_0003;
            29: return 32'h0000_0001;
            30: return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Round the reference down to WIDTH bits (2^(WIDTH-1) = pi)
    function automatic logic [WIDTH-1:0] atan_word(input int i);
        logic [63:0] t;
        int          sh;
        t  = {32'd0, atan_ref32(i)};
        sh = 32 - WIDTH;
        if (sh > 0) begin
            t = (t + (64'd1 << (sh - 1))) >> sh;
        end
        return t[WIDTH-1:0];
    endfunction

    logic [C_BIT_SPAN-1:0] rom_w [C_ITER_SPAN];

    for (genvar gi = 0; gi < C_ITER_SPAN; gi++) begin : g_rom
        if (gi < ITERS) begin : g_live
            assign rom_w[gi] = C_BIT_SPAN'(atan_word(gi));
        end else begin : g_pad
            assign rom_w[gi] = '0;
        end
    end

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   zreg_q,     zreg_d;
    logic [WIDTH-1:0]   z_out_q,    z_out_d;
    logic               carry_q,    carry_d;
    logic               dir_q,      dir_d;
    logic               mode_q,     mode_d;
    logic [ITER_W-1:0]  iter_idx_q, iter_idx_d;
    logic [BIT_W-1:0]   bit_q,      bit_d;

    logic               dir_cur;
    logic               c_in;
    logic               rom_bit;
    logic               a_bit;
    logic               sum_bit;
    logic               c_out;
    logic [WIDTH-1:0]   z_shift;

    always_comb begin
        // Direction is decided on bit 0 and held in dir_q for the rest of the word
        dir_cur = dir_q;
        if (bit_q == '0) begin
            dir_cur = mode_q ? dir_in : zreg_q[WIDTH-1];
        end
        c_in    = (bit_q == '0) ? ~dir_cur : carry_q;
        rom_bit = rom_w[iter_idx_q][bit_q];
        a_bit   = dir_cur ? rom_bit : ~rom_bit;
        sum_bit = zreg_q[0] ^ a_bit ^ c_in;
        c_out   = (zreg_q[0] & a_bit) | (zreg_q[0] & c_in) | (a_bit & c_in);
        z_shift = {sum_bit, zreg_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d    = state_q;
        zreg_d     = zreg_q;
        z_out_d    = z_out_q;
        carry_d    = carry_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        iter_idx_d = iter_idx_q;
        bit_d      = bit_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start) begin
                    state_d    = S_RUN;
                    zreg_d     = z0;
                    mode_d     = mode;
                    iter_idx_d = '0;
                    bit_d      = '0;
                end
            end
            S_RUN: begin
                zreg_d  = z_shift;
                carry_d = c_out;
                dir_d   = dir_cur;
                if (bit_q == BIT_W'(WIDTH - 1)) begin
                    bit_d      = '0;
                    iter_idx_d = iter_idx_q + ITER_W'(1);
                    if (iter_idx_q == ITER_W'(ITERS - 1)) begin
                        z_out_d = z_shift;
                        state_d = S_DONE;
                    end
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            zreg_q     <= '0;
            z_out_q    <= '0;
            carry_q    <= 1'b0;
            dir_q      <= 1'b0;
            mode_q     <= 1'b0;
            iter_idx_q <= '0;
            bit_q      <= '0;
        end else begin
            state_q    <= state_d;
            zreg_q     <= zreg_d;
            z_out_q    <= z_out_d;
            carry_q    <= carry_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            iter_idx_q <= iter_idx_d;
            bit_q      <= bit_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign z_out      = z_out_q;
    assign dir_out    = (state_q == S_RUN) ? dir_cur : dir_q;
    assign iter_start = (state_q == S_RUN) && (bit_q == '0);
    assign iter_idx   = iter_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_z_serial.sv
// ============================================================================
//  Module      : tb_cordic_z_serial
//  Description : Scoreboard bench for cordic_z_serial over four ITERS values.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cordic_z_serial;

    localparam int W = 16;
    localparam int ITERS_TAB [4] = '{16, 2, 3, 1};

    typedef struct {
        int          id;
        logic [W-1:0] z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start      [4];
    logic         mode       [4];
    logic         dir_in     [4];
    logic [W-1:0] z0         [4];
    logic         busy       [4];
    logic         done       [4];
    logic         dir_out    [4];
    logic         iter_start [4];
    logic [W-1:0] z_out      [4];
    logic [4:0]   iter_idx   [4];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        cordic_z_serial #(
            .WIDTH (W),
            .ITERS (ITERS_TAB[k]),
            .ITER_W(5),
            .BIT_W (4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[k]),
            .mode      (mode[k]),
            .z0        (z0[k]),
            .dir_in    (dir_in[k]),
            .busy      (busy[k]),
            .done      (done[k]),
            .z_out     (z_out[k]),
            .dir_out   (dir_out[k]),
            .iter_start(iter_start[k]),
            .iter_idx  (iter_idx[k])
        );
    end

    // Word-level reference: z +/- round(atan(2^-i) * 2^15 / pi)
    function automatic logic [W-1:0] model(input logic [W-1:0] z, input logic m,
                                           input logic d, input int iters);
        logic [W-1:0] r;
        logic         dd;
        int           a;
        r = z;
        for (int i = 0; i < iters; i++) begin
            a  = int'($atan(1.0 / (2.0 ** i)) * 32768.0 / 3.14159265358979);
            dd = m ? d : r[W-1];
            r  = dd ? r + W'(a) : r - W'(a);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst && done[k] === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected_done dut%0d: z_out=%h, no result queued", k, z_out[k]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.id !== k || z_out[k] !== e.z)
                        $display("FAIL sb_result dut%0d: z_out=%h, required %h from dut%0d",
                                 k, z_out[k], e.z, e.id);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic push(input int k, input logic [W-1:0] z);
        exp_t e;
        e.id = k;
        e.z  = z;
        sb.push_back(e);
    endtask

    task automatic launch(input int k, input logic [W-1:0] z, input logic m);
        @(negedge clk);
        z0[k]    = z;
        mode[k]  = m;
        start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy[0]); else n_pass++;
        n_checks++; if (done[0] !== 1'b0) $display("FAIL reset_done: got %b, required 0", done[0]); else n_pass++;
        n_checks++; if (z_out[0] !== 16'h0) $display("FAIL reset_z_out: got %h, required 0000", z_out[0]); else n_pass++;
        n_checks++; if (dir_out[0] !== 1'b0) $display("FAIL reset_dir_out: got %b, required 0", dir_out[0]); else n_pass++;
        n_checks++; if (iter_start[0] !== 1'b0) $display("FAIL reset_iter_start: got %b, required 0", iter_start[0]); else n_pass++;
        n_checks++; if (iter_idx[0] !== 5'd0) $display("FAIL reset_iter_idx: got %0d, required 0", iter_idx[0]); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_latency;
        logic [W-1:0] z, ex;
        int busy_cnt = 0, done_cnt = 0, done_n = -1, is_cnt = 0, is_first = -1;
        int last_is = -1, bad_gap = 0, unstable = 0;
        logic prev_dir = 1'b0;
        z  = W'($urandom);
        ex = model(z, 1'b0, 1'b0, 16);
        push(0, ex);
        @(negedge clk);
        z0[0] = z; mode[0] = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (busy[0]) busy_cnt++;
            if (done[0]) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (iter_start[0]) begin
                if (is_first < 0) is_first = n;
                if (last_is >= 0 && n - last_is != 16) bad_gap++;
                last_is = n;
                is_cnt++;
            end else if (busy[0] && dir_out[0] !== prev_dir) begin
                unstable++;
            end
            prev_dir = dir_out[0];
        end
        n_checks++; if (busy_cnt !== 256) $display("FAIL lat_busy_cycles: got %0d, required 256", busy_cnt); else n_pass++;
        n_checks++; if (done_n !== 256) $display("FAIL lat_done_cycle: got %0d, required 256", done_n); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL lat_done_width: got %0d, required 1", done_cnt); else n_pass++;
        n_checks++; if (is_cnt !== 16) $display("FAIL lat_iter_start_count: got %0d, required 16", is_cnt); else n_pass++;
        n_checks++; if (is_first !== 0 || bad_gap !== 0) $display("FAIL lat_iter_start_spacing: first=%0d bad_gaps=%0d, required 0/0", is_first, bad_gap); else n_pass++;
        n_checks++; if (unstable !== 0) $display("FAIL lat_dir_stable: changes=%0d, required 0", unstable); else n_pass++;
        n_checks++; if (z_out[0] !== ex) $display("FAIL lat_z_out_hold: got %h, required %h", z_out[0], ex); else n_pass++;
    endtask

    task automatic test_rotation;
        int   done_n = -1, nd = 0;
        logic dirs [4];
        push(1, 16'hF2E4);
        launch(1, 16'h0000, 1'b0);
        for (int n = 0; n < 100 && done_n < 0; n++) begin
            @(negedge clk);
            if (iter_start[1] && nd < 4) begin
                dirs[nd] = dir_out[1];
                nd++;
            end
            if (done[1]) done_n = n;
        end
        n_checks++; if (done_n !== 32) $display("FAIL rot_done_cycle: got %0d, required 32", done_n); else n_pass++;
        n_checks++; if (nd !== 2) $display("FAIL rot_iter_count: got %0d, required 2", nd); else n_pass++;
        n_checks++; if (nd < 2 || dirs[0] !== 1'b0 || dirs[1] !== 1'b1)
            $display("FAIL rot_dir_seq: got %b%b, required 01", dirs[0], dirs[1]); else n_pass++;
    endtask

    task automatic test_vectoring;
        int done_n = -1;
        push(2, 16'h3CDF);
        launch(2, 16'h0000, 1'b1);
        for (int n = 0; n < 100 && done_n < 0; n++) begin
            @(negedge clk);
            dir_in[2] = iter_start[2] ? 1'b1 : 1'($urandom);
            if (done[2]) done_n = n;
        end
        dir_in[2] = 1'b0;
        n_checks++; if (done_n !== 48) $display("FAIL vec_done_cycle: got %0d, required 48", done_n); else n_pass++;
    endtask

    task automatic test_wrap;
        int done_n = -1;
        dir_in[3] = 1'b1;
        push(3, 16'h9000);
        launch(3, 16'h7000, 1'b1);
        for (int n = 0; n < 60 && done_n < 0; n++) begin
            @(negedge clk);
            if (done[3]) done_n = n;
        end
        n_checks++; if (done_n !== 16) $display("FAIL wrap_done_cycle: got %0d, required 16", done_n); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int   d1 = -1, d2 = -1;
        logic b33 = 1'b0, b66 = 1'b1;
        push(1, 16'hF2E4);
        push(1, model(16'h1000, 1'b0, 1'b0, 2));
        @(negedge clk);
        z0[1] = 16'h0000; mode[1] = 1'b0; start[1] = 1'b1;
        @(posedge clk);
        #1 z0[1] = 16'h1000;
        for (int n = 0; n < 100 && d2 < 0; n++) begin
            @(negedge clk);
            if (n == 33) begin
                b33 = busy[1];
                start[1] = 1'b0;
            end
            if (done[1]) begin
                if (d1 < 0) d1 = n; else d2 = n;
            end
        end
        @(negedge clk);
        b66 = busy[1];
        n_checks++; if (d1 !== 32) $display("FAIL b2b_first_done: got %0d, required 32", d1); else n_pass++;
        n_checks++; if (b33 !== 1'b1) $display("FAIL b2b_no_bubble: busy=%b, required 1", b33); else n_pass++;
        n_checks++; if (d2 !== 65) $display("FAIL b2b_second_done: got %0d, required 65", d2); else n_pass++;
        n_checks++; if (b66 !== 1'b0) $display("FAIL b2b_idle_after: busy=%b, required 0", b66); else n_pass++;
    endtask

    task automatic test_ignored_start;
        int done_n = -1;
        push(1, 16'hF2E4);
        launch(1, 16'h0000, 1'b0);
        for (int n = 0; n < 100 && done_n < 0; n++) begin
            @(negedge clk);
            if (n == 5) begin
                z0[1] = 16'h1234; mode[1] = 1'b1; start[1] = 1'b1;
            end
            if (n == 6) begin
                start[1] = 1'b0;
                n_checks++; if (iter_idx[1] !== 5'd0 || busy[1] !== 1'b1)
                    $display("FAIL ign_mid_run: iter_idx=%0d busy=%b, required 0/1", iter_idx[1], busy[1]); else n_pass++;
            end
            if (n == 20) begin
                n_checks++; if (iter_idx[1] !== 5'd1)
                    $display("FAIL ign_iter_idx: got %0d, required 1", iter_idx[1]); else n_pass++;
            end
            if (done[1]) done_n = n;
        end
        n_checks++; if (done_n !== 32) $display("FAIL ign_done_cycle: got %0d, required 32", done_n); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int done_n = -1;
        launch(0, 16'h4321, 1'b0);
        repeat (38) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0)
            $display("FAIL rstmid_flags: busy=%b done=%b, required 0/0", busy[0], done[0]); else n_pass++;
        n_checks++; if (z_out[0] !== 16'h0 || z_out[1] !== 16'h0)
            $display("FAIL rstmid_z_out: dut0=%h dut1=%h, required 0000", z_out[0], z_out[1]); else n_pass++;
        n_checks++; if (iter_idx[0] !== 5'd0)
            $display("FAIL rstmid_iter_idx: got %0d, required 0", iter_idx[0]); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        push(1, 16'hF2E4);
        launch(1, 16'h0000, 1'b0);
        for (int n = 0; n < 100 && done_n < 0; n++) begin
            @(negedge clk);
            if (done[1]) done_n = n;
        end
        n_checks++; if (done_n !== 32) $display("FAIL rstmid_rerun_done: got %0d, required 32", done_n); else n_pass++;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            start[k]  = 1'b0;
            mode[k]   = 1'b0;
            dir_in[k] = 1'b0;
            z0[k]     = '0;
        end
        test_reset();
        test_latency();
        test_rotation();
        test_vectoring();
        test_wrap();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d results never produced, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
